// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART receive/transmit path: frame
//            width, oversampling counter width, the receiver state encoding
//            and the clocks-per-oversample-tick helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Data bits per frame (8N1).
  localparam int UART_DATA_BITS = 8;

  // Width of the per-bit oversample counter (16 ticks per bit).
  localparam int UART_OS_BITS = 4;

  // Receiver states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int uart_tick_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_os_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_os_tick
// Purpose  : Oversample tick divider. Emits a one-cycle tick every TICK_DIV
//            clocks. A synchronous clear restarts the count so the tick phase
//            can be aligned to an external event (e.g. start-bit detection).
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            clr  - synchronous clear of the divider (suppresses the tick)
//            tick - one-cycle pulse when the divider wraps
// Revision : 1.0 - initial release
// ============================================================================
module uart_os_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

  generate
    if (TICK_DIV < 1) begin : g_bad_tick_div
      $error("uart_os_tick: TICK_DIV must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic             wrap;

  always_comb begin
    wrap      = (div_cnt_q == C_LAST);
    div_cnt_d = div_cnt_q + 1'b1;
    if (clr || wrap) begin
      div_cnt_d = '0;
    end
    // While cleared the count is held at zero, so the first tick after the
    // clear is released lands exactly TICK_DIV cycles later.
    tick = wrap && !clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with 16x oversampling and a 3-sample majority
//            vote per bit. Delivers each good byte with a one-cycle rx_ok
//            strobe and flags a low stop bit with a one-cycle rx_frame_err.
// Ports    : clk          - system clock (single domain)
//            rst          - synchronous active-high reset
//            rx           - asynchronous serial input, idles high
//            rx_data      - last good byte, held until the next good frame
//            rx_ok        - one-cycle strobe, rx_data valid in same cycle
//            rx_frame_err - one-cycle strobe, stop bit sampled low
//            rx_busy      - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = uart_tick_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_ok,
  output logic                      rx_frame_err,
  output logic                      rx_busy
);

  generate
    if (OVERSAMPLE != 16) begin : g_bad_oversample
      $error("uart_rx: only OVERSAMPLE = 16 is supported");
    end
  endgenerate

  localparam logic [UART_OS_BITS-1:0] C_OS_S0   = 4'd7;   // first vote sample
  localparam logic [UART_OS_BITS-1:0] C_OS_S1   = 4'd8;   // second vote sample
  localparam logic [UART_OS_BITS-1:0] C_OS_DEC  = 4'd9;   // third sample + decision
  localparam logic [UART_OS_BITS-1:0] C_OS_LAST = 4'd15;  // last tick of a bit
  localparam logic [2:0]              C_LAST_BIT = 3'(UART_DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  uart_state_e               state_q,     state_d;
  logic [1:0]                sync_q,      sync_d;
  logic                      rxs_prev_q,  rxs_prev_d;
  logic [UART_OS_BITS-1:0]   os_cnt_q,    os_cnt_d;
  logic [2:0]                bit_idx_q,   bit_idx_d;
  logic [1:0]                samp_q,      samp_d;
  logic [UART_DATA_BITS-1:0] shreg_q,     shreg_d;
  logic [UART_DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                      rx_ok_q,     rx_ok_d;
  logic                      frame_err_q, frame_err_d;

  logic rxs;
  logic fall;
  logic tick;
  logic decide;
  logic bit_end;
  logic majority;
  logic tick_clr;

  // --------------------------------------------------------------------------
  // Oversample tick: held in clear while idle so that tick phase is referenced
  // to the cycle the start edge was detected.
  // --------------------------------------------------------------------------
  assign tick_clr = (state_q == IDLE);

  uart_os_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_os_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  always_comb begin
    rxs     = sync_q[1];
    fall    = rxs_prev_q & ~rxs;
    decide  = tick && (os_cnt_q == C_OS_DEC);
    bit_end = tick && (os_cnt_q == C_OS_LAST);
    // Two stored samples plus the live one taken on the decision tick.
    majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx};
    rxs_prev_d  = rxs;
    os_cnt_d    = os_cnt_q;
    bit_idx_d   = bit_idx_q;
    samp_d      = samp_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_ok_d     = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != IDLE && tick) begin
      os_cnt_d = os_cnt_q + 1'b1;  // wraps 15 -> 0 naturally
      if (os_cnt_q == C_OS_S0) begin
        samp_d[0] = rxs;
      end
      if (os_cnt_q == C_OS_S1) begin
        samp_d[1] = rxs;
      end
    end

    case (state_q)
      IDLE: begin
        os_cnt_d  = '0;
        bit_idx_d = '0;
        if (fall) begin
          state_d = START;
        end
      end

      START: begin
        if (decide && majority) begin
          // Start bit did not hold low through mid-bit: treat as a glitch.
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (decide) begin
          shreg_d = {majority, shreg_q[UART_DATA_BITS-1:1]};
        end
        if (bit_end) begin
          if (bit_idx_q == C_LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (decide) begin
          if (majority) begin
            rx_data_d = shreg_q;
            rx_ok_d   = 1'b1;
            // Leave mid-stop-bit so the next start edge has margin to be seen.
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      BREAK: begin
        // Hold here until the line returns high; a long break reports once.
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      rxs_prev_q  <= 1'b1;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      samp_q      <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_ok_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rxs_prev_q  <= rxs_prev_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      samp_q      <= samp_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_ok_q     <= rx_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_ok        = rx_ok_q;
  assign rx_frame_err = frame_err_q;
  assign rx_busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Frames are generated from a
//            bit list at a chosen line rate; an expected-event queue holds
//            what each frame must produce and one monitor compares every
//            cycle against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int  CLK_FREQ = 1600000;
  localparam int  BAUD     = 100000;
  localparam real BIT_CLKS = 16.0;
  // Strobe expected 157 cycles after the first low cycle of the line:
  // 2 sync + detect, stop decision at 16*9+10, registered strobe.
  localparam int  LAT_MIN  = 155;
  localparam int  LAT_MAX  = 159;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ok;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_ok        (rx_ok),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned fall;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned ok_cyc[$];
  logic [7:0]  exp_data = 8'h00;
  int          err_seen = 0;
  logic        prev_ok  = 1'b0;
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: every cycle the outputs are compared against the event queue
  // and the last-good-byte model.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    ev_t ev;
    if (rst) begin
      exp_data = 8'h00;
    end else begin
      check("strobe_exclusive", 32'(rx_ok & rx_frame_err), 32'd0);
      check("ok_one_cycle", 32'(prev_ok & rx_ok), 32'd0);
      check("err_one_cycle", 32'(prev_err & rx_frame_err), 32'd0);
      if (rx_ok || rx_frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'({rx_ok, rx_frame_err}), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check("strobe_kind_err", 32'(rx_frame_err), 32'(ev.is_err));
          check("strobe_latency",
                32'((cyc - ev.fall) >= LAT_MIN && (cyc - ev.fall) <= LAT_MAX), 32'd1);
          if (rx_ok) begin
            check("strobe_data", 32'(rx_data), 32'(ev.data));
            exp_data = ev.data;
            ok_cyc.push_back(cyc);
          end
          if (rx_frame_err) err_seen++;
        end
      end else if (exp_q.size() > 0 && (cyc - exp_q[0].fall) > 200) begin
        check("strobe_timeout", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      check("rx_data_hold", 32'(rx_data), 32'(exp_data));
    end
    prev_ok  = rx_ok;
    prev_err = rx_frame_err;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive one 8N1 frame. per = clocks per bit (may be fractional).
  // glitch_at inverts the line for that one frame cycle; rst_at pulses reset
  // at that frame cycle and abandons the frame. Negative disables either.
  task automatic send_frame(input logic [7:0] data, input real per, input bit stop_bit,
                            input int glitch_at, input int rst_at);
    logic [9:0] bits;
    int b0;
    int b1;
    bits = {stop_bit, data, 1'b0};
    if (rst_at < 0) exp_q.push_back('{is_err: !stop_bit, data: data, fall: cyc});
    for (int k = 0; k < 10; k++) begin
      b0 = $rtoi(k * per + 0.5);
      b1 = $rtoi((k + 1) * per + 0.5);
      for (int n = b0; n < b1; n++) begin
        if (n == rst_at) begin
          rst = 1'b1;
          rx  = 1'b1;
          step();
          check("rst_mid_rx_data", 32'(rx_data), 32'h00);
          check("rst_mid_rx_ok", 32'(rx_ok), 32'd0);
          check("rst_mid_frame_err", 32'(rx_frame_err), 32'd0);
          check("rst_mid_busy", 32'(rx_busy), 32'd0);
          rst = 1'b0;
          return;
        end
        rx = (n == glitch_at) ? ~bits[k] : bits[k];
        step();
      end
    end
    rx = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int hi;
    int n_ok;
    int n_err;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) step();
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_ok", 32'(rx_ok), 32'd0);
    check("reset_frame_err", 32'(rx_frame_err), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(10);

    // Good frames
    send_frame(8'hA5, BIT_CLKS, 1'b1, -1, -1); idle(8);
    check("good_A5", 32'(rx_data), 32'hA5);
    send_frame(8'h00, BIT_CLKS, 1'b1, -1, -1); idle(8);
    check("good_00", 32'(rx_data), 32'h00);
    send_frame(8'hFF, BIT_CLKS, 1'b1, -1, -1); idle(8);
    check("good_FF", 32'(rx_data), 32'hFF);
    check("no_err_after_good", 32'(err_seen), 32'd0);

    // One-clock glitch mid data bit 3 (line samples at frame cycles 72..74)
    send_frame(8'h00, BIT_CLKS, 1'b1, 73, -1); idle(8);
    check("glitch_bit3_outvoted", 32'(rx_data), 32'h00);

    // Back-to-back, zero gap
    n_ok = ok_cyc.size();
    send_frame(8'h55, BIT_CLKS, 1'b1, -1, -1);
    send_frame(8'h3C, BIT_CLKS, 1'b1, -1, -1); idle(8);
    check("b2b_count", 32'(ok_cyc.size() - n_ok), 32'd2);
    if (ok_cyc.size() - n_ok == 2) begin
      check("b2b_spacing",
            32'((ok_cyc[n_ok+1] - ok_cyc[n_ok]) >= 158 && (ok_cyc[n_ok+1] - ok_cyc[n_ok]) <= 162),
            32'd1);
    end
    check("b2b_data_3C", 32'(rx_data), 32'h3C);

    // Framing error, then a good frame
    n_err = err_seen;
    send_frame(8'h81, BIT_CLKS, 1'b0, -1, -1); idle(16);
    check("ferr_count", 32'(err_seen - n_err), 32'd1);
    check("ferr_data_kept", 32'(rx_data), 32'h3C);
    send_frame(8'h42, BIT_CLKS, 1'b1, -1, -1); idle(8);
    check("after_ferr_42", 32'(rx_data), 32'h42);

    // Break: 40 bit times low
    n_err = err_seen;
    exp_q.push_back('{is_err: 1'b1, data: 8'h00, fall: cyc});
    rx = 1'b0;
    for (int i = 0; i < 640; i++) step();
    check("break_busy_low_line", 32'(rx_busy), 32'd1);
    check("break_one_err", 32'(err_seen - n_err), 32'd1);
    rx = 1'b1;
    for (int i = 0; i < 8 && rx_busy; i++) step();
    check("break_back_idle", 32'(rx_busy), 32'd0);
    check("break_data_kept", 32'(rx_data), 32'h42);
    idle(8);

    // Idle-line glitch: 4 low clocks
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      rx = (i < 4) ? 1'b0 : 1'b1;
      if (rx_busy) hi++;
      step();
    end
    check("glitch_busy_rose", 32'(hi > 0), 32'd1);
    check("glitch_busy_len_le11", 32'(hi <= 11), 32'd1);
    check("glitch_back_idle", 32'(rx_busy), 32'd0);

    // Reset during data bit 4 of 8'hC3 (frame cycles 80..95)
    send_frame(8'hC3, BIT_CLKS, 1'b1, -1, 88);
    idle(200);

    // Rate tolerance: +3% and -3%
    n_ok = ok_cyc.size();
    send_frame(8'h96, BIT_CLKS / 1.03, 1'b1, -1, -1); idle(8);
    check("fast_96", 32'(rx_data), 32'h96);
    send_frame(8'h96, BIT_CLKS / 0.97, 1'b1, -1, -1); idle(8);
    check("slow_96", 32'(rx_data), 32'h96);
    check("rate_ok_count", 32'(ok_cyc.size() - n_ok), 32'd2);

    idle(220);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("total_ok", 32'(ok_cyc.size()), 32'd9);
    check("total_err", 32'(err_seen), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
